// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester byte handshake and the serializer launch/status signals for the
// uart_tx_arbiter.
//   req_valid/req_data/req_last : per-requester byte offer (4 lanes, byte i on [8i+7:8i])
//   req_ready                   : one-hot accept pulse back to the requesters
//   o_Tx_DV/o_Tx_Byte           : launch pulse and byte to the uart_tx serializer
//   i_Tx_Active/i_Tx_Done       : serializer status
// Modports:
//   master : arbiter side
//   slave  : environment side (requesters + serializer)
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;

  modport master (
    input  req_valid, req_data, req_last, i_Tx_Active, i_Tx_Done,
    output req_ready, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    output req_valid, req_data, req_last, i_Tx_Active, i_Tx_Done,
    input  req_ready, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_tx serializer between 4 byte sources. One byte is
// captured per transfer from the granted requester and launched with a 1-cycle o_Tx_DV pulse;
// the next byte is served only after the serializer reports completion. A granted requester
// keeps the serializer until it sends a byte flagged last, so frames never interleave.
// Ports:
//   osc_clk     : system clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : uart_tx_arbiter_if.master (requester handshake + serializer link)
//   grant_id    : index of current/last granted requester (3 after reset)
//   lock        : frame in progress, grant held
//   busy        : FSM not idle
//   err_timeout : sticky serializer-hang flag
// Optional feature macro: ARB_TIMEOUT_EN (serializer watchdog; without it err_timeout is 0 and
// the wait states wait forever).
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT   = 1155,
  parameter int unsigned TIMEOUT_CYCLES = 11 * CLKS_PER_BIT + 64
) (
  input  logic               osc_clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus,
  output logic [1:0]         grant_id,
  output logic               lock,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLoad,
    StWaitStart,
    StWaitDone
  } state_e;

  state_e     state_q;
  logic       done_q;
  logic [1:0] next_grant;
  logic [1:0] scan_idx;
  logic       found;
  logic       any_valid;
  logic       ser_idle;
  logic       done_rise;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  assign cnt_inc = cnt_q + 16'd1;
`else
  assign err_timeout = 1'b0;
`endif

  assign any_valid = |bus.req_valid;
  assign ser_idle  = !bus.i_Tx_Active && !bus.i_Tx_Done;
  // Done is high for 2 cycles; only its first cycle counts as a completion.
  assign done_rise = bus.i_Tx_Done && !done_q;
  assign busy      = (state_q != StIdle);

  // Scan grant_id+1 .. grant_id+4 so the last winner has the lowest priority.
  always_comb begin
    next_grant = grant_id;
    scan_idx   = grant_id;
    found      = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = grant_id + 2'(i);
      if (!found && bus.req_valid[scan_idx]) begin
        next_grant = scan_idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      done_q        <= 1'b0;
      grant_id      <= 2'd3;
      lock          <= 1'b0;
      bus.req_ready <= 4'b0000;
      bus.o_Tx_DV   <= 1'b0;
      bus.o_Tx_Byte <= 8'h00;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= 16'd0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      done_q        <= bus.i_Tx_Done;
      bus.req_ready <= 4'b0000;
      bus.o_Tx_DV   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // While locked, only the owner of the frame may continue.
          if (lock ? bus.req_valid[grant_id] : any_valid) state_q <= StArb;
        end
        StArb: begin
          if (lock) begin
            state_q <= StLoad;
          end else if (any_valid) begin
            grant_id <= next_grant;
            state_q  <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          if (ser_idle) begin
            bus.o_Tx_DV   <= 1'b1;
            bus.o_Tx_Byte <= bus.req_data[8*grant_id +: 8];
            bus.req_ready <= 4'b0001 << grant_id;
            lock          <= ~bus.req_last[grant_id];
            state_q       <= StWaitStart;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= 16'd0;
`endif
          end
        end
        StWaitStart: begin
`ifdef ARB_TIMEOUT_EN
          cnt_q <= cnt_inc;
          if (bus.i_Tx_Active) begin
            state_q <= StWaitDone;
          end else if (cnt_inc == 16'd16) begin
            err_timeout <= 1'b1;
            lock        <= 1'b0;
            state_q     <= StIdle;
          end
`else
          if (bus.i_Tx_Active) state_q <= StWaitDone;
`endif
        end
        StWaitDone: begin
`ifdef ARB_TIMEOUT_EN
          cnt_q <= cnt_inc;
          if (done_rise) begin
            state_q <= StIdle;
          end else if (cnt_inc >= TimeoutLim) begin
            err_timeout <= 1'b1;
            lock        <= 1'b0;
            state_q     <= StIdle;
          end
`else
          if (done_rise) state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomized bench for uart_tx_arbiter. Requesters hold per-lane byte queues; a serializer model
// produces Active/Done with random timing. The expected launch sequence is derived from the
// round-robin/frame-lock rules over the queued bytes and compared at every o_Tx_DV.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] req;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic       osc_clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       lock;
  logic       busy;
  logic       err_timeout;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter dut (
    .osc_clk     (osc_clk),
    .rst         (rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .lock        (lock),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 osc_clk = ~osc_clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] rq[4][$];     // {last, data} per requester
  logic [3:0] hold;         // forces a requester's valid low
  exp_t       exp_q[$];
  int         m_last;
  bit         m_lock;
  int         dv_count = 0;
  int         unexpected_dv = 0;
  int         ser_t, ser_d, ser_len;
  bit         ser_mute;

  exp_t        e;
  logic [3:0]  vv, ll;
  logic [31:0] dd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: serve queued bytes by round-robin from the last winner, sticking to a requester
  // until it sends a byte flagged last.
  task automatic build_expected();
    logic [8:0] q[4][$];
    logic [8:0] item;
    int cur;
    for (int r = 0; r < 4; r++) q[r] = rq[r];
    forever begin
      if (m_lock) begin
        cur = m_last;
        if (q[cur].size() == 0) break;
      end else begin
        cur = -1;
        for (int k = 1; k <= 4; k++)
          if (cur < 0 && q[(m_last + k) % 4].size() > 0) cur = (m_last + k) % 4;
        if (cur < 0) break;
      end
      item = q[cur].pop_front();
      exp_q.push_back('{req: 2'(cur), last: item[8], data: item[7:0]});
      m_last = cur;
      m_lock = !item[8];
    end
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_tx_dv", 32'(bus.o_Tx_DV), 0);
    chk("rst_tx_byte", 32'(bus.o_Tx_Byte), 0);
    chk("rst_grant_id", 32'(grant_id), 3);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
  endtask

  task automatic do_reset();
    @(posedge osc_clk); #3;
    rst = 1'b1;
    @(posedge osc_clk); #3;
    check_reset_values();
    rst = 1'b0;
    exp_q.delete();
    m_last = 3;
    m_lock = 1'b0;
  endtask

  task automatic wait_dv(input int target, input int budget);
    int n = 0;
    while (dv_count < target && n < budget) begin
      @(posedge osc_clk); #3;
      n++;
    end
    chk("wait_dv", 32'(dv_count >= target), 1);
  endtask

  function automatic bit all_drained();
    bit empty = 1'b1;
    for (int r = 0; r < 4; r++) if (rq[r].size() != 0) empty = 1'b0;
    return empty && exp_q.size() == 0 && !busy && ser_t < 0;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!all_drained() && n < budget) begin
      @(posedge osc_clk); #3;
      n++;
    end
    chk("drain_exp_left", 32'(exp_q.size()), 0);
    chk("extra_dv", 32'(unexpected_dv), 0);
  endtask

  // Per-cycle monitor, serializer model and requester driver in one process to avoid races.
  initial begin
    forever begin
      @(posedge osc_clk); #1;
      if (bus.o_Tx_DV) begin
        dv_count++;
        chk("ser_idle_at_dv", {30'b0, bus.i_Tx_Active, bus.i_Tx_Done}, 0);
        if (exp_q.size() == 0) begin
          unexpected_dv++;
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(bus.o_Tx_Byte), 32'(e.data));
          chk("req_ready", 32'(bus.req_ready), 32'(1) << e.req);
          chk("grant_id", 32'(grant_id), 32'(e.req));
          chk("lock_after_load", 32'(lock), 32'(!e.last));
        end
      end else begin
        chk("ready_without_dv", 32'(bus.req_ready), 0);
      end

      if (ser_t >= 0) begin
        ser_t++;
        if (ser_t > ser_d + ser_len + 2) ser_t = -1;
      end
      if (bus.o_Tx_DV && ser_t < 0 && !ser_mute) begin
        ser_t   = 0;
        ser_d   = int'($urandom_range(0, 2));
        ser_len = int'($urandom_range(16, 40));
      end
      bus.i_Tx_Active = (ser_t > ser_d) && (ser_t <= ser_d + ser_len);
      bus.i_Tx_Done   = (ser_t > ser_d + ser_len) && (ser_t <= ser_d + ser_len + 2);

      for (int r = 0; r < 4; r++)
        if (bus.req_ready[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      vv = 4'b0000;
      ll = 4'b0000;
      dd = 32'h0;
      for (int r = 0; r < 4; r++) begin
        if (rq[r].size() > 0) begin
          vv[r]        = !hold[r];
          ll[r]        = rq[r][0][8];
          dd[8*r +: 8] = rq[r][0][7:0];
        end
      end
      bus.req_valid = vv;
      bus.req_last  = ll;
      bus.req_data  = dd;
    end
  end

  initial begin
    int base;
    int n;
    int nf;
    int len;
    rst             = 1'b1;
    bus.req_valid   = 4'b0000;
    bus.req_data    = 32'h0;
    bus.req_last    = 4'b0000;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done   = 1'b0;
    hold            = 4'b0000;
    ser_t           = -1;
    ser_d           = 0;
    ser_len         = 0;
    ser_mute        = 1'b0;
    m_last          = 3;
    m_lock          = 1'b0;

    // Single byte from requester 0.
    do_reset();
    rq[0].push_back({1'b1, 8'hA5});
    build_expected();
    wait_drain(2000);
    chk("single_lock", 32'(lock), 0);
    chk("single_grant", 32'(grant_id), 0);

    // Contention: all four hold single-byte frames.
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++) rq[r].push_back({1'b1, 8'(32'h10 + r)});
    build_expected();
    wait_drain(5000);

    // Frame lock with a requester stall mid-frame.
    do_reset();
    rq[1].push_back({1'b0, 8'h31});
    rq[1].push_back({1'b0, 8'h32});
    rq[1].push_back({1'b1, 8'h33});
    rq[2].push_back({1'b1, 8'h2F});
    build_expected();
    base = dv_count;
    wait_dv(base + 1, 300);
    hold[1] = 1'b1;
    repeat (100) @(posedge osc_clk);
    #3;
    chk("locked_lock", 32'(lock), 1);
    chk("locked_no_dv", 32'(dv_count), 32'(base + 1));
    chk("locked_idle", 32'(busy), 0);
    chk("locked_grant", 32'(grant_id), 1);
    hold[1] = 1'b0;
    wait_drain(5000);

    // Reset while a locked frame is in WAIT_DONE.
    do_reset();
    for (int b = 0; b < 3; b++) rq[0].push_back({b == 2, 8'(32'h50 + b)});
    rq[2].push_back({1'b1, 8'h7E});
    build_expected();
    base = dv_count;
    wait_dv(base + 1, 300);
    n = 0;
    while (!bus.i_Tx_Active && n < 50) begin
      @(posedge osc_clk); #3;
      n++;
    end
    repeat (3) @(posedge osc_clk);
    do_reset();
    build_expected();
    wait_drain(5000);

    // Randomized frames on all lanes, no reset between rounds.
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < 4; r++) begin
        nf = int'($urandom_range(0, 2));
        for (int f = 0; f < nf; f++) begin
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) rq[r].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_expected();
      wait_drain(8000);
    end

`ifdef ARB_TIMEOUT_EN
    // Serializer never starts: watchdog fires 16 cycles after DV.
    do_reset();
    ser_mute = 1'b1;
    rq[0].push_back({1'b0, 8'h3C});
    rq[0].push_back({1'b1, 8'hC3});
    build_expected();
    base = dv_count;
    wait_dv(base + 1, 300);
    hold[0] = 1'b1;
    n = 0;
    while (!err_timeout && n < 100) begin
      @(posedge osc_clk); #3;
      n++;
    end
    chk("timeout_delay", 32'(n), 16);
    chk("timeout_lock", 32'(lock), 0);
    chk("timeout_idle", 32'(busy), 0);
    repeat (10) @(posedge osc_clk);
    #3;
    chk("timeout_sticky", 32'(err_timeout), 1);
    ser_mute = 1'b0;
    do_reset();
    hold[0] = 1'b0;
    build_expected();
    wait_drain(3000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx serializer between 4 byte sources (ADC sample packetizer, status/debug, etc.). Captures one byte per transfer from the granted requester, launches it with a single-cycle o_Tx_DV pulse, and waits for the serializer to finish before serving the next byte. Supports multi-byte frames: a granted requester keeps the serializer until it sends a byte flagged last, so frames are never interleaved.

Parameters:
CLKS_PER_BIT, 1155, serializer bit period in osc_clk cycles; used only to size the timeout.
TIMEOUT_CYCLES, 11*CLKS_PER_BIT+64, max osc_clk cycles allowed in WAIT_DONE (timeout feature only).

Ports:
osc_clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  4  per-requester byte valid; requester holds valid/data/last stable until its ready pulse
req_data  in  32  byte of requester i on bits [8i+7:8i]
req_last  in  4  per-requester: current byte ends the frame
req_ready  out  4  one-hot, 1-cycle pulse: byte of requester i accepted this cycle
o_Tx_DV  out  1  to serializer i_Tx_DV, 1-cycle pulse
o_Tx_Byte  out  8  to serializer i_Tx_Byte, registered, held until next load
i_Tx_Active  in  1  from serializer o_Tx_Active
i_Tx_Done  in  1  from serializer o_Tx_Done (high 2 cycles per byte)
grant_id  out  2  index of current/last granted requester
lock  out  1  frame in progress (grant held)
busy  out  1  state != IDLE
err_timeout  out  1  sticky serializer-hang flag

Behaviour:
- Reset (rst=1 at clock edge, any state): state=IDLE, req_ready=0, o_Tx_DV=0, o_Tx_Byte=0, grant_id=3 (so requester 0 has first priority), lock=0, busy=0, err_timeout=0, counters=0. Reset mid-byte abandons the frame; the serializer finishes its byte independently; arbiter does not launch again until serializer is idle.
- Serializer idle = i_Tx_Active==0 and i_Tx_Done==0.
- States:
  IDLE: if lock=0 and any req_valid -> ARB. If lock=1 and req_valid[grant_id] -> ARB. Otherwise stay; other requesters are ignored while locked.
  ARB (1 cycle): if lock=0, pick first valid requester scanning grant_id+1, +2, +3, +4 (mod 4) and register it into grant_id. If lock=1, keep grant_id. -> LOAD.
  LOAD: wait for serializer idle. When idle: o_Tx_DV=1, o_Tx_Byte=req_data[grant_id], req_ready[grant_id]=1 (all same cycle, 1 cycle wide). lock <= ~req_last[grant_id]. -> WAIT_START.
  WAIT_START: wait for i_Tx_Active=1 -> WAIT_DONE.
  WAIT_DONE: on rising edge of i_Tx_Done (registered delay compare) -> IDLE.
- Requester valid dropping while locked: the lock is held and the arbiter waits in IDLE indefinitely; there is no forced release except reset or timeout.
- Minimum gap: DV to next DV = serializer byte time + ~4 cycles; the serializer never sees DV while not idle.
- req_ready is never asserted for more than one requester, and never while o_Tx_DV=0.

Optional Feature:
ARB_TIMEOUT_EN: when defined, a 16-bit counter clears on entry to WAIT_START and increments in WAIT_START/WAIT_DONE. If it reaches 16 in WAIT_START, or TIMEOUT_CYCLES in WAIT_DONE: set err_timeout (sticky until rst), clear lock, -> IDLE. When undefined: no counter; err_timeout is tied to 0; WAIT states wait forever.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[7:0]=0xA5, last=1; serializer model -> one DV with o_Tx_Byte=0xA5, req_ready=4'b0001 in the same cycle, lock=0 after, UART line shows 0xA5.
- Contention: all 4 valid with single-byte frames 0x10..0x13, held continuously -> grant order 0,1,2,3,0, one byte each, no DV while i_Tx_Active=1.
- Frame lock: req1 sends 3 bytes (last on 3rd) while req2 is valid -> bytes 1,1,1 and then 2. Also drop req1 valid between bytes 1 and 2 for 100 cycles -> req2 stays blocked, lock=1.
- Done width: i_Tx_Done held 2 cycles -> exactly one completion; next DV only after Done=0.
- Reset mid-frame: assert rst for 1 cycle in WAIT_DONE of a locked frame -> all outputs at reset values next cycle, lock=0, grant_id=3; next DV only after serializer idle.
- With ARB_TIMEOUT_EN: serializer model never asserts Active -> err_timeout=1 sixteen cycles after DV, state IDLE, lock=0, sticky until rst.
